// File: rtl/vector_processor.sv
// vector_processor: 512x32 word memory feeding four 16-lane vector registers with lane-wise signed multiply and add
module vector_processor #(
  parameter int LANES = 16,
  parameter int DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]           data_in,
  input  logic                  write_enable,
  input  logic                  reg_write_enable,
  input  logic [2:0]            sel_reg_write,
  input  logic [2:0]            sel_reg_read1,
  input  logic [2:0]            sel_reg_read2,
  output logic [32*LANES-1:0]   A1,
  output logic [32*LANES-1:0]   A2,
  output logic [32*LANES-1:0]   A3,
  output logic [32*LANES-1:0]   A4,
  output logic [31:0]           data_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = 32 * LANES;
  logic [31:0] mem_q [DEPTH];
  logic [3:0][VW-1:0] a_q, a_d;
  logic [VW-1:0] op1, op2, ld, lo, hi, sum;
  // Selects 4..7 read as an all-zero vector
  assign op1 = sel_reg_read1[2] ? '0 : a_q[sel_reg_read1[1:0]];
  assign op2 = sel_reg_read2[2] ? '0 : a_q[sel_reg_read2[1:0]];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [31:0] x, y;
    logic signed [63:0] p;
    assign x = op1[32*l +: 32];
    assign y = op2[32*l +: 32];
    assign p = 64'(x) * 64'(y);
    assign lo[32*l +: 32] = p[31:0];
    assign hi[32*l +: 32] = p[63:32];
    assign sum[32*l +: 32] = x + y;
    // Load address wraps naturally in the AW-bit index
    assign ld[32*l +: 32] = mem_q[addr + AW'(l)];
  end
  // Decode register operation; every operand comes from pre-edge state
  always_comb begin
    a_d = a_q;
    if (reg_write_enable) begin
      if (!sel_reg_write[2]) a_d[sel_reg_write[1:0]] = ld;
      else if (sel_reg_write[1:0] == 2'd0) begin
        a_d[2] = lo;
        a_d[3] = hi;
      end else if (sel_reg_write[1:0] == 2'd1) a_d[2] = sum;
    end
  end
  // Vector register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_q <= '0;
    else a_q <= a_d;
  end
  // Word memory; loads in the same cycle see the pre-write contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (write_enable) mem_q[addr] <= data_in;
  end
  assign A1 = a_q[0];
  assign A2 = a_q[1];
  assign A3 = a_q[2];
  assign A4 = a_q[3];
  assign data_out = mem_q[addr];
endmodule

// File: tb/tb_vector_processor.sv
// tb_vector_processor: directed self-checking bench for vector_processor
module tb_vector_processor;
  logic clk, rst;
  logic [8:0] addr;
  logic [31:0] data_in;
  logic write_enable, reg_write_enable;
  logic [2:0] sel_reg_write, sel_reg_read1, sel_reg_read2;
  logic [511:0] A1, A2, A3, A4;
  logic [31:0] data_out;
  int tests, fails;
  logic [511:0] ea1, ea2, ea3, ea4;

  vector_processor dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .reg_write_enable(reg_write_enable),
    .sel_reg_write(sel_reg_write), .sel_reg_read1(sel_reg_read1),
    .sel_reg_read2(sel_reg_read2), .A1(A1), .A2(A2), .A3(A3), .A4(A4),
    .data_out(data_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input logic [511:0] v, input int i);
    return v[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    write_enable = 0;
    reg_write_enable = 0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    addr = a; data_in = d; write_enable = 1;
    tick();
  endtask

  task automatic rop(input logic [2:0] s, input logic [8:0] a, input logic [2:0] r1, input logic [2:0] r2);
    addr = a; sel_reg_write = s; sel_reg_read1 = r1; sel_reg_read2 = r2; reg_write_enable = 1;
    tick();
  endtask

  task automatic test_reset();
    tests++; if ({A1, A2, A3, A4} !== '0) begin fails++; $display("FAIL reset_regs got nonzero registers A1=%h", A1); end
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_mem got %h want 0", data_out); end
    rst = 0;
    tick();
  endtask

  task automatic test_word();
    wr(9'd0, 32'hAABBCCDD);
    tests++; if (data_out !== 32'hAABBCCDD) begin fails++; $display("FAIL word0 got %h want AABBCCDD", data_out); end
    wr(9'd1, 32'h11223344);
    tests++; if (data_out !== 32'h11223344) begin fails++; $display("FAIL word1 got %h want 11223344", data_out); end
    addr = 9'd0; #1;
    tests++; if (data_out !== 32'hAABBCCDD) begin fails++; $display("FAIL word0_kept got %h want AABBCCDD", data_out); end
  endtask

  task automatic test_load();
    for (int k = 0; k < 16; k++) wr(9'(k), 32'(k + 1));
    rop(3'd0, 9'd0, 3'd7, 3'd7);
    for (int i = 0; i < 16; i++) ea1[32*i +: 32] = 32'(i + 1);
    tests++; if (A1 !== ea1) begin fails++; $display("FAIL load_a1 got %h want %h", A1, ea1); end
    tests++; if ({A2, A3, A4} !== '0) begin fails++; $display("FAIL load_others got A2=%h", A2); end
    for (int k = 16; k < 32; k++) wr(9'(k), 32'd2);
    rop(3'd1, 9'd16, 3'd0, 3'd0);
    for (int i = 0; i < 16; i++) ea2[32*i +: 32] = 32'd2;
    tests++; if (A2 !== ea2) begin fails++; $display("FAIL load_a2 got %h want %h", A2, ea2); end
    tests++; if (A1 !== ea1) begin fails++; $display("FAIL load_a1_held got %h want %h", A1, ea1); end
  endtask

  task automatic test_mul();
    rop(3'd4, 9'd0, 3'd0, 3'd1);
    for (int i = 0; i < 16; i++) ea3[32*i +: 32] = 32'(2 * (i + 1));
    ea4 = '0;
    tests++; if (A3 !== ea3) begin fails++; $display("FAIL mul_lo got %h want %h", A3, ea3); end
    tests++; if (A4 !== ea4) begin fails++; $display("FAIL mul_hi got %h want %h", A4, ea4); end
    wr(9'd0, 32'hFFFFFFFF);
    rop(3'd0, 9'd0, 3'd0, 3'd0);
    ea1[31:0] = 32'hFFFFFFFF;
    tests++; if (A1 !== ea1) begin fails++; $display("FAIL mul_setup got %h want %h", A1, ea1); end
    rop(3'd4, 9'd0, 3'd0, 3'd1);
    ea3[31:0] = 32'hFFFFFFFE;
    ea4[31:0] = 32'hFFFFFFFF;
    tests++; if (lane(A3, 0) !== 32'hFFFFFFFE) begin fails++; $display("FAIL mul_neg_lo got %h want FFFFFFFE", lane(A3, 0)); end
    tests++; if (lane(A4, 0) !== 32'hFFFFFFFF) begin fails++; $display("FAIL mul_neg_hi got %h want FFFFFFFF", lane(A4, 0)); end
    tests++; if (A3 !== ea3 || A4 !== ea4) begin fails++; $display("FAIL mul_neg_all got A3=%h A4=%h", A3, A4); end
  endtask

  task automatic test_wrap();
    wr(9'd510, 32'h0000510A);
    wr(9'd511, 32'h0000511B);
    rop(3'd3, 9'd510, 3'd0, 3'd1);
    ea4[31:0] = 32'h0000510A;
    ea4[63:32] = 32'h0000511B;
    ea4[95:64] = 32'hFFFFFFFF;
    for (int j = 3; j < 16; j++) ea4[32*j +: 32] = 32'(j - 1);
    tests++; if (lane(A4, 2) !== 32'hFFFFFFFF) begin fails++; $display("FAIL wrap_lane2 got %h want FFFFFFFF", lane(A4, 2)); end
    tests++; if (A4 !== ea4) begin fails++; $display("FAIL wrap_all got %h want %h", A4, ea4); end
  endtask

  task automatic test_hazard();
    addr = 9'd0; data_in = 32'hDEAD0000; write_enable = 1;
    sel_reg_write = 3'd0; reg_write_enable = 1;
    tick();
    tests++; if (lane(A1, 0) !== 32'hFFFFFFFF) begin fails++; $display("FAIL hazard_old got %h want FFFFFFFF", lane(A1, 0)); end
    tests++; if (data_out !== 32'hDEAD0000) begin fails++; $display("FAIL hazard_write got %h want DEAD0000", data_out); end
  endtask

  task automatic test_add_nop();
    wr(9'd16, 32'd1);
    rop(3'd1, 9'd16, 3'd0, 3'd0);
    ea2[31:0] = 32'd1;
    rop(3'd5, 9'd0, 3'd0, 3'd1);
    ea3[31:0] = 32'd0;
    for (int i = 1; i < 16; i++) ea3[32*i +: 32] = 32'(i + 3);
    tests++; if (A3 !== ea3) begin fails++; $display("FAIL add_a3 got %h want %h", A3, ea3); end
    tests++; if (A4 !== ea4) begin fails++; $display("FAIL add_a4_held got %h want %h", A4, ea4); end
    rop(3'd5, 9'd0, 3'd4, 3'd1);
    ea3 = ea2;
    tests++; if (A3 !== ea3) begin fails++; $display("FAIL add_zero_sel got %h want %h", A3, ea3); end
    rop(3'd7, 9'd0, 3'd0, 3'd1);
    tests++; if (A1 !== ea1 || A2 !== ea2 || A3 !== ea3 || A4 !== ea4) begin fails++; $display("FAIL nop7 got A3=%h A4=%h", A3, A4); end
    rop(3'd6, 9'd0, 3'd0, 3'd1);
    tests++; if (A1 !== ea1 || A2 !== ea2 || A3 !== ea3 || A4 !== ea4) begin fails++; $display("FAIL nop6 got A3=%h A4=%h", A3, A4); end
    sel_reg_write = 3'd4;
    tick();
    tests++; if (A3 !== ea3 || A4 !== ea4) begin fails++; $display("FAIL no_strobe got A3=%h A4=%h", A3, A4); end
  endtask

  task automatic test_mid_reset();
    addr = 9'd16;
    #2 rst = 1;
    #1;
    tests++; if ({A1, A2, A3, A4} !== '0) begin fails++; $display("FAIL midrst_regs got A1=%h", A1); end
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL midrst_mem16 got %h want 0", data_out); end
    addr = 9'd511; #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL midrst_mem511 got %h want 0", data_out); end
    write_enable = 1; reg_write_enable = 1; sel_reg_write = 3'd0; data_in = 32'h5;
    @(posedge clk); #1;
    tests++; if (data_out !== 32'h0 || A1 !== '0) begin fails++; $display("FAIL midrst_wins got %h want 0", data_out); end
    write_enable = 0; reg_write_enable = 0;
    rst = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    wr(9'd0, 32'd3);
    rop(3'd0, 9'd0, 3'd0, 3'd0);
    tests++; if (A1 !== 512'd3) begin fails++; $display("FAIL b2b_load got %h want 3", A1); end
    rop(3'd4, 9'd0, 3'd0, 3'd0);
    tests++; if (A3 !== 512'd9) begin fails++; $display("FAIL b2b_sq got %h want 9", A3); end
    rop(3'd4, 9'd0, 3'd2, 3'd0);
    tests++; if (A3 !== 512'd27 || A4 !== '0) begin fails++; $display("FAIL b2b_old_op got A3=%h A4=%h want 27", A3, A4); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1; addr = 0; data_in = 0; write_enable = 0; reg_write_enable = 0;
    sel_reg_write = 0; sel_reg_read1 = 0; sel_reg_read2 = 0;
    ea1 = '0; ea2 = '0; ea3 = '0; ea4 = '0;
    #1;
    test_reset();
    test_word();
    test_load();
    test_mul();
    test_wrap();
    test_hazard();
    test_add_nop();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vector_processor.md
Name: vector_processor

Overview:
- Single-clock SIMD datapath: a 512 x 32-bit word data memory plus four 512-bit vector registers A1..A4, each holding 16 lanes of 32 bits.
- Supports word writes into memory and 16-word vector loads into A1..A4.
- Supports lane-wise signed multiply; low product halves go to A3, high halves to A4.
- Used as the vector compute block under a simple external controller that drives address, data and select lines directly.

Parameters:
- LANES, 16, number of 32-bit lanes per vector register (fixed; vector width = 32*LANES = 512).
- DEPTH, 512, number of 32-bit memory words (address width 9).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  9  word address for memory write, data_out read, and vector load base.
- data_in  input  32  word written to memory.
- write_enable  input  1  memory word write strobe.
- reg_write_enable  input  1  vector register operation strobe.
- sel_reg_write  input  3  register operation code (see Behaviour).
- sel_reg_read1  input  3  operand 1 select: 0..3 = A1..A4, 4..7 = all-zero vector.
- sel_reg_read2  input  3  operand 2 select, same encoding.
- A1, A2, A3, A4  output  512 each  vector register contents; lane i = bits [32i+31:32i].
- data_out  output  32  memory word at addr.

Behaviour:
- Reset (rst=1, asynchronous): A1..A4 <= 0; all memory words <= 0; data_out therefore reads 0. Reset wins over any simultaneous enable.
- Memory write: on rising clk with write_enable=1, mem[addr] <= data_in.
- data_out = mem[addr], combinational (asynchronous read). A write becomes visible on data_out immediately after the writing edge.
- Register operation on rising clk with reg_write_enable=1, decoded by sel_reg_write:
  - 0/1/2/3: vector load into A1/A2/A3/A4. Lane i <= mem[(addr+i) mod 512], i=0..15. Address wraps modulo 512. Read selects are ignored.
  - 4: multiply. For each lane i, P = signed(op1[i]) * signed(op2[i]), a 64-bit two's-complement product. A3 lane i <= P[31:0]; A4 lane i <= P[63:32].
  - 5: add. A3 lane i <= (op1[i] + op2[i]) mod 2^32; A4 unchanged.
  - 6, 7: no operation; all registers hold.
- Operands are always the register values before the edge. Example: multiply with op1=A3 reads the old A3.
- When reg_write_enable=0, all registers hold.
- Simultaneous write_enable and vector load in the same cycle: the load reads pre-write memory contents (read-before-write). The memory write still completes.
- Latency: one clock from strobe to register or memory update. No handshake; a new operation may be issued every cycle.
- All outputs are continuous views of state; there is no output register beyond A1..A4.

Test Plan:
- Reset: assert rst mid-cycle after loading nonzero data -> A1..A4 = 0 immediately, data_out = 0 for any addr.
- Word write/read: addr=0, data_in=32'hAABBCCDD, write_enable=1 for one edge -> data_out = AABBCCDD. Then addr=1, data_in=32'h11223344 -> data_out = 11223344, and mem[0] still reads AABBCCDD.
- Vector load: write mem[k]=k+1 for k=0..15, then addr=0, sel_reg_write=0, reg_write_enable=1 -> A1 lane i = i+1, other registers unchanged. Repeat with mem[16..31]=2 and addr=16, sel_reg_write=1 -> all A2 lanes = 2.
- Multiply: with the loads above, sel_reg_write=4, sel_reg_read1=0, sel_reg_read2=1 -> A3 lane i = 2(i+1), A4 = 0. Then set A1 lane0 = FFFFFFFF and A2 lane0 = 00000002 and multiply again -> A3 lane0 = FFFFFFFE, A4 lane0 = FFFFFFFF.
- Wrap and hazard:
  - Load with addr=510 -> lane0 = mem[510], lane1 = mem[511], lane2 = mem[0].
  - Same-cycle write mem[0]=0xDEAD0000 with load A1 from addr 0 -> A1 lane0 = old mem[0]; data_out afterwards = DEAD0000.
- Add and no-op: sel_reg_write=5 with A1 lane = 0xFFFFFFFF and A2 lane = 1 -> A3 lane = 0, A4 unchanged. sel_reg_write=7 -> no register changes.
